// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types, default sizing and parity helper for the RS232 receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    // 50 MHz core clock, 115200 baud.
    localparam int DEFAULT_CYCLES_PER_BIT = 434;
    localparam int DEFAULT_DATA_WIDTH     = 8;

    // XOR reduction over data plus parity bit; 0 means even parity holds.
    function automatic logic parity_of(input logic [9:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/rs232_rx_bit_timer.sv
// rs232_rx_bit_timer: baud counter producing mid-bit sample ticks for the receive FSM.
// Latency: sample_tick is combinational from the counter flop; counter clears on clear or tick.
// Backpressure: none; free-running. Ports: clear (restart count), half_mode (half-bit target), sample_tick.
module rs232_rx_bit_timer
    import rs232_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2,
    parameter int COUNTER_WIDTH  = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic half_mode,
    output logic sample_tick
);

    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;

    always_comb begin
        sample_tick = half_mode ? (count_q == COUNTER_WIDTH'(HALF_BIT - 1))
                                : (count_q == COUNTER_WIDTH'(CYCLES_PER_BIT - 1));
        // Clearing on the tick keeps consecutive samples exactly one bit period apart.
        count_d = (clear || sample_tick) ? '0 : count_q + COUNTER_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rs232_rx_deserializer.sv
// rs232_rx_deserializer: RS232 receiver; 2-flop rxd sync, start validation, mid-bit sampling, 1-entry output register.
// Latency: pin to FSM 2 cycles; out_valid/out_data and error pulses appear 1 cycle after the stop-bit sample.
// Backpressure: out_valid/out_ready; a character completing while the register is full and not drained is dropped with an overrun pulse.
// Ports: rxd in, out_data/out_valid/out_ready, framing_error/parity_error/overrun 1-cycle pulses.
// Optional macro RS232_RX_PARITY_EN: even parity bit between data and stop; otherwise parity_error is tied 0.
module rs232_rx_deserializer
    import rs232_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int HALF_BIT       = CYCLES_PER_BIT / 2,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int COUNTER_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  framing_error,
    output logic                  parity_error,
    output logic                  overrun
);

    localparam int BC_W = $clog2(DATA_WIDTH);

    rx_state_t             state_q, state_d;
    logic [BC_W-1:0]       bit_count_q, bit_count_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  framing_error_q, framing_error_d;
    logic                  parity_error_q, parity_error_d;
    logic                  overrun_q, overrun_d;
    logic                  rxd_meta_q, rxd_sync_q;
    logic                  complete;
    logic                  sample_tick;
    logic                  timer_clear;
`ifdef RS232_RX_PARITY_EN
    logic                  par_q, par_d;
`endif

    // Restart the baud count whenever the FSM moves to a new state.
    assign timer_clear = (state_d != state_q);

    rs232_rx_bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT),
        .HALF_BIT       (HALF_BIT),
        .COUNTER_WIDTH  (COUNTER_WIDTH)
    ) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (timer_clear),
        .half_mode   (state_q == ST_START),
        .sample_tick (sample_tick)
    );

    always_comb begin
        state_d         = state_q;
        bit_count_d     = bit_count_q;
        shift_d         = shift_q;
        out_data_d      = out_data_q;
        out_valid_d     = out_valid_q && !out_ready;
        framing_error_d = 1'b0;
        parity_error_d  = 1'b0;
        overrun_d       = 1'b0;
        complete        = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_d           = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!rxd_sync_q) state_d = ST_START;
            end
            ST_START: begin
                if (sample_tick) begin
                    if (!rxd_sync_q) begin
                        state_d     = ST_DATA;
                        bit_count_d = '0;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    shift_d     = {rxd_sync_q, shift_q[DATA_WIDTH-1:1]};
                    bit_count_d = bit_count_q + BC_W'(1);
                    if (bit_count_q == BC_W'(DATA_WIDTH - 1)) begin
`ifdef RS232_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef RS232_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_tick) begin
                    par_d   = rxd_sync_q;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (sample_tick) begin
                    if (!rxd_sync_q) begin
                        // Bad stop bit wins over any parity result.
                        framing_error_d = 1'b1;
                        state_d         = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_IDLE;
`ifdef RS232_RX_PARITY_EN
                        if (parity_of(10'({par_q, shift_q}))) parity_error_d = 1'b1;
                        else                                  complete       = 1'b1;
`else
                        complete = 1'b1;
`endif
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off through a break so it reports only one framing error.
                if (rxd_sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = shift_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q      <= 1'b1;
            rxd_sync_q      <= 1'b1;
            state_q         <= ST_IDLE;
            bit_count_q     <= '0;
            shift_q         <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            overrun_q       <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_q           <= 1'b0;
`endif
        end else begin
            rxd_meta_q      <= rxd;
            rxd_sync_q      <= rxd_meta_q;
            state_q         <= state_d;
            bit_count_q     <= bit_count_d;
            shift_q         <= shift_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            framing_error_q <= framing_error_d;
            parity_error_q  <= parity_error_d;
            overrun_q       <= overrun_d;
`ifdef RS232_RX_PARITY_EN
            par_q           <= par_d;
`endif
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign framing_error = framing_error_q;
    assign parity_error  = parity_error_q;
    assign overrun       = overrun_q;

endmodule
